// File: rtl/lcd_timing_driver_if.sv
// Pixel request bus between the LCD timing driver and the pixel source.
// The driver presents xpos/ypos/data_req; the source returns pixel_data one cycle later.
interface lcd_timing_driver_if;
    logic [15:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        data_req;

    modport master (
        input  pixel_data,
        output pixel_xpos,
        output pixel_ypos,
        output data_req
    );

    modport slave (
        output pixel_data,
        input  pixel_xpos,
        input  pixel_ypos,
        input  data_req
    );
endinterface

// File: rtl/lcd_timing_driver.sv
// Parallel-RGB LCD timing generator: HSYNC/VSYNC/DE plus a one-cycle-early
// pixel request to a registered pixel source, forwarding RGB565 to the panel.
module lcd_timing_driver #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2
) (
    input  logic                       lcd_pclk,
    input  logic                       rst,
    lcd_timing_driver_if.master        pix,
    output logic [10:0]                h_disp,
    output logic [10:0]                v_disp,
    output logic                       lcd_hs,
    output logic                       lcd_vs,
    output logic                       lcd_de,
    output logic [15:0]                lcd_rgb,
    output logic                       lcd_bl,
    output logic                       frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [10:0] HT_M1  = 11'(H_TOTAL - 1);
    localparam logic [10:0] VT_M1  = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END = 11'(H_SYNC);
    localparam logic [10:0] VS_END = 11'(V_SYNC);
    localparam logic [10:0] REQ_LO = 11'(HA - 1);
    localparam logic [10:0] REQ_HI = 11'(HA + H_DISP - 1);
    localparam logic [10:0] DE_LO  = 11'(HA);
    localparam logic [10:0] DE_HI  = 11'(HA + H_DISP);
    localparam logic [10:0] VA_LO  = 11'(VA);
    localparam logic [10:0] VA_HI  = 11'(VA + V_DISP);

    if (HA < 1) begin : g_bad_ha
        $error("H_SYNC+H_BACK must be at least 1");
    end
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
        $error("H_TOTAL and V_TOTAL must not exceed 2047");
    end

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        req_q, req_d;
    logic        fs_q, fs_d;
    logic        bl_q;
    logic        act;

    // Counters describe the position shown at the outputs; bl_q doubles
    // as the "running" flag so the first edge after reset lands on 0,0.
    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == HT_M1) begin
            h_d = '0;
            v_d = (v_q == VT_M1) ? 11'd0 : v_q + 11'd1;
        end
        if (!bl_q) begin
            h_d = '0;
            v_d = '0;
        end
        act   = (v_d >= VA_LO) && (v_d < VA_HI);
        hs_d  = (h_d >= HS_END);
        vs_d  = (v_d >= VS_END);
        de_d  = act && (h_d >= DE_LO) && (h_d < DE_HI);
        req_d = act && (h_d >= REQ_LO) && (h_d < REQ_HI);
        x_d   = req_d ? h_d - REQ_LO : 11'd0;
        y_d   = req_d ? v_d - VA_LO : 11'd0;
        fs_d  = (h_d == 11'd0) && (v_d == 11'd0);
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            req_q <= 1'b0;
            fs_q  <= 1'b0;
            bl_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            req_q <= req_d;
            fs_q  <= fs_d;
            bl_q  <= 1'b1;
        end
    end

    // Source data arrives one cycle after the request, aligned with de_q.
    assign lcd_rgb        = de_q ? pix.pixel_data : 16'h0000;
    assign pix.pixel_xpos = x_q;
    assign pix.pixel_ypos = y_q;
    assign pix.data_req   = req_q;
    assign lcd_hs         = hs_q;
    assign lcd_vs         = vs_q;
    assign lcd_de         = de_q;
    assign lcd_bl         = bl_q;
    assign frame_start    = fs_q;
    assign h_disp         = 11'(H_DISP);
    assign v_disp         = 11'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Self-checking bench for lcd_timing_driver with a small panel geometry
// and a 1-cycle registered pixel source returning {ypos, xpos, 5'h0}.
module tb_lcd_timing_driver;

    localparam int HT = 15;
    localparam int VT = 8;
    localparam int HA = 5;
    localparam int VA = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic        bl;
        logic [15:0] rgb;
        logic [10:0] hd;
        logic [10:0] vd;
    } out_t;

    logic        lcd_pclk = 1'b0;
    logic        rst = 1'b1;
    logic        frc = 1'b0;
    logic [10:0] h_disp, v_disp;
    logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
    logic [15:0] lcd_rgb;
    logic [15:0] src_q = 16'h0000;

    lcd_timing_driver_if pif ();

    lcd_timing_driver #(
        .H_SYNC (2), .H_BACK (3), .H_DISP (8), .H_FRONT (2),
        .V_SYNC (1), .V_BACK (2), .V_DISP (4), .V_FRONT (1)
    ) u_dut (
        .lcd_pclk    (lcd_pclk),
        .rst         (rst),
        .pix         (pif),
        .h_disp      (h_disp),
        .v_disp      (v_disp),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .lcd_de      (lcd_de),
        .lcd_rgb     (lcd_rgb),
        .lcd_bl      (lcd_bl),
        .frame_start (frame_start)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    always @(posedge lcd_pclk)
        src_q <= frc ? 16'hFFFF
                     : {pif.pixel_ypos[4:0], pif.pixel_xpos[5:0], 5'h0};
    assign pif.pixel_data = src_q;

    int   checks = 0;
    int   passed = 0;
    int   k = 0;
    int   ln = 0;
    bit   run = 0;
    int   cyc = 0;
    int   de_cnt = 0;
    int   fs_cnt = 0;
    int   last_fs = -1;
    int   last_hs = -1;
    logic prev_hs = 1'b1;
    out_t sb[$];

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        checks++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, o, e);
    endtask

    function automatic out_t expect_out(input bit r, input bit f);
        out_t e;
        bit   act;
        e     = '0;
        e.hd  = 11'd8;
        e.vd  = 11'd4;
        if (r) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            return e;
        end
        act   = (ln >= VA) && (ln < VA + 4);
        e.hs  = !(k < 2);
        e.vs  = !(ln < 1);
        e.de  = act && (k >= HA) && (k < HA + 8);
        e.req = act && (k >= HA - 1) && (k < HA + 7);
        e.x   = e.req ? 11'(k - HA + 1) : 11'd0;
        e.y   = e.req ? 11'(ln - VA) : 11'd0;
        e.fs  = (k == 0) && (ln == 0);
        e.bl  = 1'b1;
        if (e.de)
            e.rgb = f ? 16'hFFFF : {5'(ln - VA), 6'(k - HA), 5'h0};
        return e;
    endfunction

    task automatic step(input bit r, input bit f);
        out_t o;
        out_t e;
        @(negedge lcd_pclk);
        rst = r;
        frc = f;
        @(posedge lcd_pclk);
        if (r) begin
            run = 0;
            k = 0;
            ln = 0;
            last_fs = -1;
            last_hs = -1;
        end else if (!run) begin
            run = 1;
            k = 0;
            ln = 0;
        end else begin
            k++;
            if (k == HT) begin
                k = 0;
                ln = (ln + 1) % VT;
            end
        end
        sb.push_back(expect_out(r, f));
        #1;
        cyc++;
        o.hs  = lcd_hs;
        o.vs  = lcd_vs;
        o.de  = lcd_de;
        o.req = pif.data_req;
        o.x   = pif.pixel_xpos;
        o.y   = pif.pixel_ypos;
        o.fs  = frame_start;
        o.bl  = lcd_bl;
        o.rgb = lcd_rgb;
        o.hd  = h_disp;
        o.vd  = v_disp;
        e = sb.pop_front();
        chk("cycle", 128'(o), 128'(e));
        chk("no_x", 128'($isunknown(o)), 128'd0);
        if (o.de === 1'b1) de_cnt++;
        if (o.fs === 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) chk("fs_period", 128'(cyc - last_fs), 128'd120);
            last_fs = cyc;
        end
        if (!r && prev_hs === 1'b1 && o.hs === 1'b0) begin
            if (last_hs >= 0) chk("line_period", 128'(cyc - last_hs), 128'd15);
            last_hs = cyc;
        end
        prev_hs = o.hs;
        if (!r && !f && ln == 3 && k == 5) begin
            chk("first_px_de", 128'(lcd_de), 128'd1);
            chk("first_px_rgb", 128'(lcd_rgb), 128'h0000);
        end
        if (!r && !f && ln == 6 && k == 12)
            chk("last_px_rgb", 128'(lcd_rgb), 128'({5'd3, 6'd7, 5'd0}));
    endtask

    initial begin
        int n;
        repeat (3) step(1'b1, 1'b0);
        chk("rst_hd", 128'(h_disp), 128'd8);
        chk("rst_vd", 128'(v_disp), 128'd4);

        de_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 360; i++) begin
            step(1'b0, (i >= 120) && (i < 240));
            if (i == 0) begin
                chk("rel_fs", 128'(frame_start), 128'd1);
                chk("rel_hs", 128'(lcd_hs), 128'd0);
                chk("rel_vs", 128'(lcd_vs), 128'd0);
                chk("rel_bl", 128'(lcd_bl), 128'd1);
            end
        end
        chk("de_total_3fr", 128'(de_cnt), 128'd96);
        chk("fs_total_3fr", 128'(fs_cnt), 128'd3);

        n = 0;
        while (!(ln == 4 && k == 8) && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("reach_l4k8", 128'(n < 200), 128'd1);

        step(1'b1, 1'b0);
        chk("mid_rst_bl", 128'(lcd_bl), 128'd0);
        de_cnt = 0;
        fs_cnt = 0;
        step(1'b0, 1'b0);
        chk("mid_rel_fs", 128'(frame_start), 128'd1);
        repeat (119) step(1'b0, 1'b0);
        chk("de_after_rst", 128'(de_cnt), 128'd32);
        chk("fs_after_rst", 128'(fs_cnt), 128'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
